mfp_ahb_spi_tx: RTL and testbench

- Parametrised successor of the single-register ESP8266 2-wire transmit peripheral.
- AHB-Lite slave with three registers (DATA, STATUS, CTRL) and a FIFO that buffers software writes.
- A divided-clock serialiser shifts frames out on SCLK/IO_SPI, so software no longer waits per word.
- Sits on the MFP AHB-Lite bus beside the GPIO peripherals; selected by the system decoder via HSEL.

---
 rtl/mfp_ahb_spi_tx_pkg.sv | 43 ++++
 rtl/mfp_ahb_spi_tx_if.sv | 26 ++
 rtl/mfp_sync_fifo.sv | 61 ++++++
 rtl/mfp_ahb_spi_tx.sv | 252 +++++++++++++++++++++++++
 tb/tb_mfp_ahb_spi_tx.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mfp_ahb_spi_tx_pkg.sv
// mfp_ahb_spi_tx_pkg
//   Shared definitions for the AHB-Lite SPI-style transmit peripheral:
//   register byte offsets, STATUS/CTRL bit positions, AHB HTRANS codes and
//   the serialiser state type.
//   Optional feature macro used by the peripheral: MFP_AHB_SPI_TX_IRQ_EN.
package mfp_ahb_spi_tx_pkg;

  // Register byte offsets within the peripheral window.
  localparam logic [3:0] DATA_OFF   = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] CTRL_OFF   = 4'h8;

  // STATUS bit positions. COUNT occupies [ST_COUNT_LSB +: 8].
  localparam int ST_BUSY      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  // CTRL bit positions.
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_CLR      = 1;
  localparam int CTRL_IRQ_MASK = 2;

  // AHB-Lite transfer types that carry no transfer.
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;

  // Serialiser state encoding. The raw codes are kept as plain constants so
  // older code that compares against numeric state values keeps working.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    LOAD  = S_LOAD,
    SHIFT = S_SHIFT,
    GAP   = S_GAP
  } tx_state_t;

endpackage

// File: rtl/mfp_ahb_spi_tx_if.sv
// mfp_ahb_spi_tx_if
//   AHB-Lite slave-side bus bundle for mfp_ahb_spi_tx.
//   HSEL/HWRITE/HTRANS/HADDR : address phase, driven by the master/decoder
//   HWDATA                   : write data, data phase, driven by the master
//   HRDATA                   : read data, data phase, driven by the slave
//   Handshake: zero-wait-state slave, so there is no HREADY; every accepted
//   address phase (HSEL with HTRANS NONSEQ/SEQ) is followed by exactly one
//   data-phase cycle in which HWDATA is consumed or HRDATA is valid.
interface mfp_ahb_spi_tx_if;
  logic        HSEL;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [3:0]  HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HWRITE, HTRANS, HADDR, HWDATA,
    input  HRDATA
  );

  modport slave (
    input  HSEL, HWRITE, HTRANS, HADDR, HWDATA,
    output HRDATA
  );
endinterface

// File: rtl/mfp_sync_fifo.sv
// mfp_sync_fifo
//   Single-clock FIFO, reusable by other peripherals.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data; dropped while full (even if a pop
//                happens in the same cycle)
//   pop, dout  : read request; dout always shows the head entry
//   clr        : synchronous flush; wins over a simultaneous push
//   full, empty, count : occupancy
//   Pointers carry one extra wrap bit so full and empty can be told apart by
//   comparing the MSBs.
module mfp_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  input  logic          clr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];

  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until a push has written it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mfp_ahb_spi_tx.sv
// mfp_ahb_spi_tx
//   AHB-Lite transmit peripheral: software pushes words into a FIFO through
//   DATA, and a divided-clock serialiser shifts them out MSB first on
//   SCLK/IO_SPI, with a quiet GAP between frames as the frame delimiter.
//   Ports:
//     HCLK, HRESETn : clock, asynchronous active-low reset
//     bus           : AHB-Lite slave bundle (mfp_ahb_spi_tx_if.slave)
//     SCLK, IO_SPI  : serial clock (idles low) and serial data
//     IRQ           : "all data sent" interrupt, 0 unless built with
//                     MFP_AHB_SPI_TX_IRQ_EN
//     fsm_state     : current serialiser state, for debug/observation
//   Registers: 0x0 DATA (W), 0x4 STATUS (R), 0x8 CTRL (R/W).
//   Optional feature macro: MFP_AHB_SPI_TX_IRQ_EN (enables IRQ and CTRL[2]).
module mfp_ahb_spi_tx
  import mfp_ahb_spi_tx_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 50
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  mfp_ahb_spi_tx_if.slave  bus,
  output logic             SCLK,
  output logic             IO_SPI,
  output logic             IRQ,
  output tx_state_t        fsm_state
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DVW = $clog2(2 * CLK_DIV);

  localparam logic [DVW-1:0] HALF_TC  = DVW'(CLK_DIV - 1);
  localparam logic [DVW-1:0] GAP_TC   = DVW'(2 * CLK_DIV - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  // ---------------------------------------------------------------------
  // Bus front end: capture the address phase, act in the data phase.
  // ---------------------------------------------------------------------
  logic       dp_sel;
  logic       dp_write;
  logic [3:0] dp_off;
  logic       wr_en;
  logic       data_wr;
  logic       ctrl_wr;
  logic       clr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_sel   <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
    end else begin
      dp_sel   <= bus.HSEL && (bus.HTRANS != HTRANS_IDLE) &&
                  (bus.HTRANS != HTRANS_BUSY);
      dp_write <= bus.HWRITE;
      dp_off   <= bus.HADDR;
    end
  end

  assign wr_en   = dp_sel && dp_write;
  assign data_wr = wr_en && (dp_off == DATA_OFF);
  assign ctrl_wr = wr_en && (dp_off == CTRL_OFF);
  assign clr     = ctrl_wr && bus.HWDATA[CTRL_CLR];

  // Only the low DATA_W bits and a few CTRL bits are consumed.
  logic unused_hwdata;
  assign unused_hwdata = ^bus.HWDATA;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_count;

  mfp_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (data_wr),
    .din   (bus.HWDATA[DATA_W-1:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .clr   (clr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------------
  // CTRL / OVF
  // ---------------------------------------------------------------------
  logic ctrl_enable;
  logic ovf;
  logic irq_mask;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_enable <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_enable <= bus.HWDATA[CTRL_ENABLE];
      // CLR wins over a push into a full FIFO in the same cycle.
      if (clr)
        ovf <= 1'b0;
      else if (data_wr && fifo_full)
        ovf <= 1'b1;
    end
  end

`ifdef MFP_AHB_SPI_TX_IRQ_EN
  logic irq_mask_nx;
  logic irq_q;
  logic push_taken;

  assign irq_mask_nx = ctrl_wr ? bus.HWDATA[CTRL_IRQ_MASK] : irq_mask;
  // A push that is not flushed makes the FIFO non-empty next cycle, so IRQ
  // is dropped on the same edge the entry lands.
  assign push_taken  = data_wr && !clr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_mask <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_mask <= irq_mask_nx;
      irq_q    <= irq_mask_nx && fifo_empty && !push_taken &&
                  (fsm_state == IDLE);
    end
  end

  assign IRQ = irq_q;
`else
  assign irq_mask = 1'b0;
  assign IRQ      = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Register read path (combinational from the registered offset)
  // ---------------------------------------------------------------------
  logic [31:0] status_word;
  logic [31:0] ctrl_word;

  always_comb begin
    status_word                        = '0;
    status_word[ST_BUSY]               = (fsm_state != IDLE);
    status_word[ST_EMPTY]              = fifo_empty;
    status_word[ST_FULL]               = fifo_full;
    status_word[ST_OVF]                = ovf;
    status_word[ST_COUNT_LSB +: 8]     = 8'(fifo_count);
  end

  always_comb begin
    ctrl_word                = '0;
    ctrl_word[CTRL_ENABLE]   = ctrl_enable;
    ctrl_word[CTRL_IRQ_MASK] = irq_mask;
  end

  always_comb begin
    bus.HRDATA = '0;
    case (dp_off)
      STATUS_OFF: bus.HRDATA = status_word;
      CTRL_OFF:   bus.HRDATA = ctrl_word;
      default:    bus.HRDATA = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nx;
  logic [BCW-1:0]    bit_cnt;
  logic [DVW-1:0]    div_cnt;

  // IDLE pops on the cycle it is entered, which keeps back-to-back frames
  // separated by exactly GAP plus one cycle.
  assign fifo_pop = (fsm_state == IDLE) && ctrl_enable && !fifo_empty;
  assign shreg_nx = shreg << 1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fsm_state <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      SCLK      <= 1'b0;
      IO_SPI    <= 1'b0;
    end else begin
      case (fsm_state)
        IDLE: begin
          SCLK   <= 1'b0;
          IO_SPI <= 1'b0;
          if (fifo_pop) begin
            shreg     <= fifo_dout;
            fsm_state <= LOAD;
          end
        end

        LOAD: begin
          IO_SPI    <= shreg[DATA_W-1];
          bit_cnt   <= LAST_BIT;
          div_cnt   <= '0;
          fsm_state <= SHIFT;
        end

        SHIFT: begin
          if (div_cnt == HALF_TC) begin
            div_cnt <= '0;
            if (!SCLK) begin
              SCLK <= 1'b1;
            end else begin
              // Falling edge: either the frame is done or the next bit is
              // presented a full half-period ahead of the next rise.
              SCLK <= 1'b0;
              if (bit_cnt == '0) begin
                IO_SPI    <= 1'b0;
                fsm_state <= GAP;
              end else begin
                shreg   <= shreg_nx;
                IO_SPI  <= shreg_nx[DATA_W-1];
                bit_cnt <= bit_cnt - 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        GAP: begin
          SCLK   <= 1'b0;
          IO_SPI <= 1'b0;
          if (div_cnt == GAP_TC) begin
            div_cnt   <= '0;
            fsm_state <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: fsm_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_spi_tx.sv
module tb_mfp_ahb_spi_tx;
  import mfp_ahb_spi_tx_pkg::*;

  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CLK_DIV    = 2;
  localparam int BIT_CYC    = 2 * CLK_DIV;
  // Start-to-start distance of back-to-back frames: LOAD/SHIFT + GAP + IDLE.
  localparam int FRAME_CYC  = 1 + 2 * CLK_DIV * DATA_W + 2 * CLK_DIV + 1;

  logic      HCLK;
  logic      HRESETn;
  logic      SCLK;
  logic      IO_SPI;
  logic      IRQ;
  tx_state_t fsm_state;

  mfp_ahb_spi_tx_if bus ();

  mfp_ahb_spi_tx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus),
    .SCLK      (SCLK),
    .IO_SPI    (IO_SPI),
    .IRQ       (IRQ),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- serial monitor ----------------
  logic [DATA_W-1:0] got_q[$];
  int                rise_t[$];
  int                frame_start_q[$];
  logic [DATA_W-1:0] acc;
  int                bit_n = 0;
  int                cyc   = 0;
  logic              sclk_q = 1'b0;

  always @(negedge HCLK) begin
    cyc = cyc + 1;
    if (!HRESETn) begin
      bit_n  = 0;
      sclk_q = 1'b0;
    end else begin
      if (SCLK && !sclk_q) begin
        acc = {acc[DATA_W-2:0], IO_SPI};
        rise_t.push_back(cyc);
        if (bit_n == 0) frame_start_q.push_back(cyc);
        bit_n = bit_n + 1;
        if (bit_n == DATA_W) begin
          got_q.push_back(acc);
          bit_n = 0;
        end
      end
      sclk_q = SCLK;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] model_fifo[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                model_ovf = 1'b0;

  task automatic model_push(input logic [DATA_W-1:0] d);
    if (model_fifo.size() < FIFO_DEPTH) model_fifo.push_back(d);
    else model_ovf = 1'b1;
  endtask

  task automatic model_clear();
    model_fifo.delete();
    model_ovf = 1'b0;
  endtask

  // Enabling the serialiser sends everything the FIFO holds, in order.
  task automatic model_drain();
    while (model_fifo.size() > 0) exp_q.push_back(model_fifo.pop_front());
  endtask

  function automatic logic [31:0] model_status(input bit busy);
    logic [31:0] s;
    s = 32'(model_fifo.size()) << 8;
    s[3] = model_ovf;
    s[2] = (model_fifo.size() == FIFO_DEPTH);
    s[1] = (model_fifo.size() == 0);
    s[0] = busy;
    return s;
  endfunction

  task automatic clear_monitor();
    got_q.delete();
    rise_t.delete();
    frame_start_q.delete();
    exp_q.delete();
  endtask

  // ---------------- bus driver ----------------
  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HWRITE = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HADDR  = 4'h0;
    bus.HWDATA = 32'h0;
  endtask

  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HWRITE = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = a;
    @(negedge HCLK);
    bus.HSEL   = 1'b0;
    bus.HWRITE = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWDATA = d;
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HWRITE = 1'b0;
    bus.HTRANS = 2'b10;
    bus.HADDR  = a;
    @(negedge HCLK);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    d = bus.HRDATA;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge HCLK);
    n_checks++;
    if (got_q.size() !== n)
      $display("FAIL wait_frames: got %0d frames, required %0d", got_q.size(), n);
    else n_pass++;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && fsm_state != IDLE; i++) @(negedge HCLK);
  endtask

  task automatic compare_frames(input string tag);
    while (exp_q.size() > 0) begin
      logic [DATA_W-1:0] e;
      logic [DATA_W-1:0] g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      n_checks++;
      if (g !== e) $display("FAIL %s frame: got %h, required %h", tag, g, e);
      else n_pass++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] r;
    n_checks++;
    if (bus.HRDATA !== 32'h0 || SCLK !== 1'b0 || IO_SPI !== 1'b0 || IRQ !== 1'b0)
      $display("FAIL reset_outputs: hrdata=%h sclk=%b io=%b irq=%b, required all 0",
               bus.HRDATA, SCLK, IO_SPI, IRQ);
    else n_pass++;
    ahb_read(STATUS_OFF, r);
    n_checks++;
    if (r !== model_status(1'b0)) $display("FAIL reset_status: got %h, required %h", r, model_status(1'b0));
    else n_pass++;
    ahb_read(CTRL_OFF, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL reset_ctrl: got %h, required 0", r);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [31:0] r;
    int bad;
    int gap_n;
    clear_monitor();
    ahb_write(CTRL_OFF, 32'h1);
    ahb_write(DATA_OFF, 32'hFFFF_A5C3);
    model_push(16'hA5C3);
    model_drain();
    wait_frames(1, 300);
    gap_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      if (fsm_state == GAP) gap_n++;
      else if (gap_n > 0) break;
    end
    compare_frames("single");
    n_checks++;
    if (rise_t.size() !== DATA_W) $display("FAIL single_rises: got %0d, required %0d", rise_t.size(), DATA_W);
    else n_pass++;
    bad = 0;
    for (int i = 1; i < rise_t.size(); i++)
      if (rise_t[i] - rise_t[i-1] != BIT_CYC) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL single_spacing: %0d intervals off, required 0", bad);
    else n_pass++;
    n_checks++;
    if (gap_n !== 2 * CLK_DIV) $display("FAIL single_gap: got %0d cycles, required %0d", gap_n, 2 * CLK_DIV);
    else n_pass++;
    ahb_read(STATUS_OFF, r);
    n_checks++;
    if (r !== model_status(1'b0)) $display("FAIL single_status: got %h, required %h", r, model_status(1'b0));
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    clear_monitor();
    ahb_write(CTRL_OFF, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      ahb_write(DATA_OFF, 32'h1111 * i);
      model_push(16'(32'h1111 * i));
    end
    ahb_read(STATUS_OFF, r);
    n_checks++;
    if (r !== model_status(1'b0)) $display("FAIL ovf_status: got %h, required %h", r, model_status(1'b0));
    else n_pass++;
    ahb_write(CTRL_OFF, 32'h1);
    model_drain();
    wait_frames(4, 600);
    repeat (200) @(negedge HCLK);
    n_checks++;
    if (got_q.size() !== 4) $display("FAIL ovf_extra: got %0d frames, required 4", got_q.size());
    else n_pass++;
    compare_frames("ovf");
    ahb_read(STATUS_OFF, r);
    n_checks++;
    if (r !== model_status(1'b0)) $display("FAIL ovf_sticky: got %h, required %h", r, model_status(1'b0));
    else n_pass++;
    ahb_write(CTRL_OFF, 32'h2);
    model_clear();
    ahb_read(STATUS_OFF, r);
    n_checks++;
    if (r !== model_status(1'b0)) $display("FAIL ovf_clr: got %h, required %h", r, model_status(1'b0));
    else n_pass++;
  endtask

  task automatic test_clr_mid_frame();
    logic [31:0] r;
    logic [DATA_W-1:0] w;
    clear_monitor();
    for (int i = 0; i < 5; i++) begin
      w = DATA_W'($urandom);
      ahb_write(DATA_OFF, 32'(w));
      model_push(w);
    end
    ahb_write(CTRL_OFF, 32'h1);
    exp_q.push_back(model_fifo[0]);
    for (int i = 0; i < 200 && rise_t.size() < 4; i++) @(negedge HCLK);
    ahb_write(CTRL_OFF, 32'h3);
    model_clear();
    ahb_read(STATUS_OFF, r);
    n_checks++;
    if (r !== model_status(1'b1)) $display("FAIL clr_status: got %h, required %h", r, model_status(1'b1));
    else n_pass++;
    wait_frames(1, 300);
    repeat (200) @(negedge HCLK);
    n_checks++;
    if (got_q.size() !== 1) $display("FAIL clr_extra: got %0d frames, required 1", got_q.size());
    else n_pass++;
    compare_frames("clr");
    ahb_read(STATUS_OFF, r);
    n_checks++;
    if (r !== model_status(1'b0)) $display("FAIL clr_after: got %h, required %h", r, model_status(1'b0));
    else n_pass++;
    ahb_write(CTRL_OFF, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [DATA_W-1:0] w;
    int n;
    for (int round = 0; round < 3; round++) begin
      clear_monitor();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        w = DATA_W'($urandom);
        ahb_write(DATA_OFF, 32'(w));
        model_push(w);
      end
      ahb_read(STATUS_OFF, r);
      n_checks++;
      if (r !== model_status(1'b0)) $display("FAIL rand_status round %0d: got %h, required %h", round, r, model_status(1'b0));
      else n_pass++;
      ahb_write(CTRL_OFF, 32'h1);
      n = model_fifo.size();
      model_drain();
      wait_frames(n, 100 * (n + 1));
      compare_frames("rand");
      wait_idle(50);
      ahb_write(CTRL_OFF, 32'h2);
      model_clear();
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] w;
    int bad;
    clear_monitor();
    ahb_write(CTRL_OFF, 32'h1);
    for (int i = 0; i < 3; i++) begin
      w = DATA_W'($urandom);
      ahb_write(DATA_OFF, 32'(w));
      model_push(w);
    end
    model_drain();
    wait_frames(3, 400);
    compare_frames("b2b");
    bad = 0;
    for (int i = 1; i < frame_start_q.size(); i++)
      if (frame_start_q[i] - frame_start_q[i-1] != FRAME_CYC) bad++;
    n_checks++;
    if (bad !== 0 || frame_start_q.size() !== 3)
      $display("FAIL b2b_period: %0d periods off of %0d starts, required 0 off with 3 starts (period %0d)",
               bad, frame_start_q.size(), FRAME_CYC);
    else n_pass++;
    wait_idle(50);
    ahb_write(CTRL_OFF, 32'h0);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    clear_monitor();
    ahb_write(CTRL_OFF, 32'h1);
    ahb_write(DATA_OFF, 32'hFFFF);
    for (int i = 0; i < 200 && !(SCLK && IO_SPI); i++) @(negedge HCLK);
    n_checks++;
    if (SCLK !== 1'b1 || IO_SPI !== 1'b1) $display("FAIL rst_pre: sclk=%b io=%b, required 1 1", SCLK, IO_SPI);
    else n_pass++;
    #2 HRESETn = 1'b0;
    #1;
    n_checks++;
    if (SCLK !== 1'b0 || IO_SPI !== 1'b0) $display("FAIL rst_async: sclk=%b io=%b, required 0 0", SCLK, IO_SPI);
    else n_pass++;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    model_clear();
    clear_monitor();
    ahb_read(STATUS_OFF, r);
    n_checks++;
    if (r !== model_status(1'b0)) $display("FAIL rst_status: got %h, required %h", r, model_status(1'b0));
    else n_pass++;
    repeat (200) @(negedge HCLK);
    n_checks++;
    if (rise_t.size() !== 0) $display("FAIL rst_residual: got %0d SCLK rises, required 0", rise_t.size());
    else n_pass++;
  endtask

  task automatic test_ctrl_readback();
    logic [31:0] r;
    logic [31:0] e;
`ifdef MFP_AHB_SPI_TX_IRQ_EN
    e = 32'h5;
`else
    e = 32'h1;
`endif
    ahb_write(CTRL_OFF, 32'h7);
    ahb_read(CTRL_OFF, r);
    n_checks++;
    if (r !== e) $display("FAIL ctrl_readback: got %h, required %h", r, e);
    else n_pass++;
    ahb_read(4'hC, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL unmapped_read: got %h, required 0", r);
    else n_pass++;
    ahb_write(CTRL_OFF, 32'h0);
  endtask

  task automatic test_irq();
    logic [31:0] r;
    clear_monitor();
    ahb_write(CTRL_OFF, 32'h5);
`ifdef MFP_AHB_SPI_TX_IRQ_EN
    repeat (2) @(negedge HCLK);
    n_checks++;
    if (IRQ !== 1'b1) $display("FAIL irq_idle: got %b, required 1", IRQ);
    else n_pass++;
    ahb_write(DATA_OFF, 32'h00C3);
    @(negedge HCLK);
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL irq_drop: got %b, required 0", IRQ);
    else n_pass++;
    exp_q.push_back(16'h00C3);
    wait_frames(1, 300);
    for (int i = 0; i < 20 && IRQ !== 1'b1; i++) @(negedge HCLK);
    n_checks++;
    if (IRQ !== 1'b1 || fsm_state != IDLE) $display("FAIL irq_rise: irq=%b state=%0d, required 1 and IDLE", IRQ, fsm_state);
    else n_pass++;
    compare_frames("irq");
    ahb_write(CTRL_OFF, 32'h1);
    @(negedge HCLK);
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL irq_unmask: got %b, required 0", IRQ);
    else n_pass++;
`else
    ahb_write(DATA_OFF, 32'h00C3);
    exp_q.push_back(16'h00C3);
    wait_frames(1, 300);
    repeat (10) @(negedge HCLK);
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL irq_tied: got %b, required 0", IRQ);
    else n_pass++;
    compare_frames("irq");
`endif
    ahb_read(STATUS_OFF, r);
    n_checks++;
    if (r !== model_status(1'b0)) $display("FAIL irq_status: got %h, required %h", r, model_status(1'b0));
    else n_pass++;
    ahb_write(CTRL_OFF, 32'h0);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    HRESETn = 1'b0;
    bus_idle();
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    test_reset();
    test_single_frame();
    test_overflow();
    test_clr_mid_frame();
    test_random();
    test_back_to_back();
    test_ctrl_readback();
    test_irq();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
